byte_stream_assembler: RTL and testbench

//  Single-clock receive end of the 8-bit serial link: accepts one byte per qualified cycle and

---
 rtl/byte_stream_assembler_pkg.sv | 26 ++
 rtl/byte_shift_acc.sv | 34 +++
 rtl/byte_stream_assembler.sv | 109 ++++++++++
 tb/tb_byte_stream_assembler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_stream_assembler_pkg.sv
// Shared constants for the byte stream assembler: mode codes, word sizes, FSM states.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package byte_stream_assembler_pkg;

    localparam logic [1:0] MODE_8    = 2'b00;
    localparam logic [1:0] MODE_16   = 2'b01;
    localparam logic [1:0] MODE_32   = 2'b10;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    // Number of bytes that make one word in the given mode; 0 for the idle code.
    function automatic logic [2:0] bytes_per_mode(input logic [1:0] mode);
        case (mode)
            MODE_8:  bytes_per_mode = 3'd1;
            MODE_16: bytes_per_mode = 3'd2;
            MODE_32: bytes_per_mode = 3'd4;
            default: bytes_per_mode = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/byte_shift_acc.sv
// Partial-word store: up to three bytes held MSB-first, plus a count of bytes held.
// Latency: 1 clk, the new contents are visible after the edge.
// Backpressure: none; the controls are already gated by the caller's enable.
module byte_shift_acc #(
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  shift,
    input  logic [BYTE_W-1:0]     din,
    output logic [3*BYTE_W-1:0]   sr,
    output logic [1:0]            cnt
);

    // A load starts a fresh word and takes priority over a clear issued in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= 2'd0;
        end else if (load) begin
            sr  <= {{(2*BYTE_W){1'b0}}, din};
            cnt <= 2'd1;
        end else if (clr) begin
            sr  <= '0;
            cnt <= 2'd0;
        end else if (shift) begin
            sr  <= {sr[2*BYTE_W-1:0], din};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/byte_stream_assembler.sv
// Reassembles 8/16/32-bit words from a qualified byte stream, MSB first.
// Latency: 1 clk from the last byte's posedge to the word and its strobe.
// Backpressure: none; enb=0 freezes all state and forces strobes to 0.
module byte_stream_assembler
    import byte_stream_assembler_pkg::*;
#(
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic [1:0]            dataS,
    input  logic                  validIn,
    input  logic [BYTE_W-1:0]     dataIn,
    output logic [BYTE_W-1:0]     dataOut,
    output logic [2*BYTE_W-1:0]   dataOut16,
    output logic [4*BYTE_W-1:0]   dataOut32,
    output logic                  valid8,
    output logic                  valid16,
    output logic                  valid32,
    output logic                  errFrame
);

    state_t                 state;
    logic [1:0]             modeLat;
    logic [3*BYTE_W-1:0]    sr;
    logic [1:0]             cnt;

    logic                   accept;
    logic [2:0]             need;
    logic                   modeChg;
    logic                   done;
    logic                   startWord;
    logic                   accClr;
    logic                   accShift;

    // Decode this cycle's action. A mode change into 8-bit mode drops the incoming byte along
    // with the partial word so that errFrame and valid8 never pulse in the same cycle.
    always_comb begin
        accept    = enb && validIn && (dataS != MODE_IDLE);
        need      = bytes_per_mode(dataS);
        modeChg   = enb && (state == ST_COLLECT) && (dataS != modeLat);
        done      = accept && (state == ST_COLLECT) && !modeChg
                    && (({1'b0, cnt} + 3'd1) == need);
        startWord = accept && (need != 3'd1) && ((state == ST_IDLE) || modeChg);
        accClr    = done || modeChg;
        accShift  = accept && (state == ST_COLLECT) && !modeChg && !done;
    end

    byte_shift_acc #(
        .BYTE_W (BYTE_W)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (accClr),
        .load  (startWord),
        .shift (accShift),
        .din   (dataIn),
        .sr    (sr),
        .cnt   (cnt)
    );

    // FSM, mode latch, word registers and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            modeLat   <= MODE_8;
            dataOut   <= '0;
            dataOut16 <= '0;
            dataOut32 <= '0;
            valid8    <= 1'b0;
            valid16   <= 1'b0;
            valid32   <= 1'b0;
            errFrame  <= 1'b0;
        end else begin
            valid8   <= 1'b0;
            valid16  <= 1'b0;
            valid32  <= 1'b0;
            errFrame <= 1'b0;
            if (modeChg) begin
                errFrame <= 1'b1;
                if (startWord) begin
                    state   <= ST_COLLECT;
                    modeLat <= dataS;
                end else begin
                    state   <= ST_IDLE;
                end
            end else if (accept && state == ST_IDLE) begin
                if (need == 3'd1) begin
                    dataOut <= dataIn;
                    valid8  <= 1'b1;
                end else begin
                    state   <= ST_COLLECT;
                    modeLat <= dataS;
                end
            end else if (done) begin
                state <= ST_IDLE;
                if (modeLat == MODE_16) begin
                    dataOut16 <= {sr[BYTE_W-1:0], dataIn};
                    valid16   <= 1'b1;
                end else begin
                    dataOut32 <= {sr, dataIn};
                    valid32   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_stream_assembler.sv
// Bench for byte_stream_assembler: directed vector table followed by randomized traffic
// checked against a queue-based word model.
// Latency: outputs are compared 1 time unit after each posedge.
module tb_byte_stream_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enb;
    logic [1:0]  dataS;
    logic        validIn;
    logic [7:0]  dataIn;
    logic [7:0]  dataOut;
    logic [15:0] dataOut16;
    logic [31:0] dataOut32;
    logic        valid8, valid16, valid32, errFrame;

    int tests  = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    byte_stream_assembler #(.BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .dataS     (dataS),
        .validIn   (validIn),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .dataOut16 (dataOut16),
        .dataOut32 (dataOut32),
        .valid8    (valid8),
        .valid16   (valid16),
        .valid32   (valid32),
        .errFrame  (errFrame)
    );

    // One directed step: inputs applied for a cycle, outputs expected after that edge.
    // stb is {valid8, valid16, valid32, errFrame}.
    typedef struct {
        logic        rst;
        logic        enb;
        logic [1:0]  ds;
        logic        vi;
        logic [7:0]  din;
        logic [7:0]  e8;
        logic [15:0] e16;
        logic [31:0] e32;
        logic [3:0]  stb;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic r, input logic e, input logic [1:0] ds, input logic vi,
                        input logic [7:0] din, input logic [7:0] e8, input logic [15:0] e16,
                        input logic [31:0] e32, input logic [3:0] stb, input string name);
        vec_t v;
        v.rst = r; v.enb = e; v.ds = ds; v.vi = vi; v.din = din;
        v.e8 = e8; v.e16 = e16; v.e32 = e32; v.stb = stb; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] e8, input logic [15:0] e16,
                         input logic [31:0] e32, input logic [3:0] stb);
        logic [59:0] act, exp;
        act = {dataOut, dataOut16, dataOut32, valid8, valid16, valid32, errFrame};
        exp = {e8, e16, e32, stb};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got d8=%h d16=%h d32=%h stb=%b, expected d8=%h d16=%h d32=%h stb=%b",
                     name, dataOut, dataOut16, dataOut32,
                     {valid8, valid16, valid32, errFrame}, e8, e16, e32, stb);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] ds, input logic vi,
                         input logic [7:0] din);
        rst = r; enb = e; dataS = ds; validIn = vi; dataIn = din;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of bytes for the word in progress and the mode it was started in.
    logic [7:0]  mq[$];
    logic [1:0]  mMode;
    logic [7:0]  m8;
    logic [15:0] m16;
    logic [31:0] m32;
    logic [3:0]  mStb;

    function automatic int nBytes(input logic [1:0] mode);
        case (mode)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    task automatic modelStep(input logic r, input logic e, input logic [1:0] ds, input logic vi,
                             input logic [7:0] din);
        logic [31:0] w;
        if (r) begin
            mq.delete(); m8 = 0; m16 = 0; m32 = 0; mStb = 0;
            return;
        end
        mStb = 0;
        if (!e) return;
        if (mq.size() > 0 && ds != mMode) begin
            mStb = 4'b0001;
            mq.delete();
            // A byte arriving with the switch opens a new multi-byte word; an 8-bit switch loses it.
            if (ds != 2'b11 && vi && nBytes(ds) > 1) begin
                mq.push_back(din);
                mMode = ds;
            end
            return;
        end
        if (ds == 2'b11 || !vi) return;
        if (mq.size() == 0) mMode = ds;
        mq.push_back(din);
        if (mq.size() == nBytes(mMode)) begin
            w = 0;
            foreach (mq[i]) w = (w << 8) | 32'(mq[i]);
            case (mMode)
                2'b00:   begin m8  = w[7:0];  mStb = 4'b1000; end
                2'b01:   begin m16 = w[15:0]; mStb = 4'b0100; end
                default: begin m32 = w;       mStb = 4'b0010; end
            endcase
            mq.delete();
        end
    endtask

    initial begin
        logic        r, e, vi;
        logic [1:0]  ds;
        logic [7:0]  din;

        rst = 1'b1; enb = 1'b1; dataS = 2'b00; validIn = 1'b0; dataIn = 8'h00;

        // Reset, then 8-bit words back to back
        for (int i = 0; i < 4; i++) addv(1,1,2'b00,0,8'h00, 8'h00,16'h0,32'h0,4'b0000,"reset");
        addv(0,1,2'b00,1,8'h49, 8'h49,16'h0,32'h0,4'b1000,"m8_49");
        addv(0,1,2'b00,1,8'h76, 8'h76,16'h0,32'h0,4'b1000,"m8_76");
        addv(0,1,2'b00,1,8'hdf, 8'hdf,16'h0,32'h0,4'b1000,"m8_df");
        addv(0,1,2'b00,0,8'h00, 8'hdf,16'h0,32'h0,4'b0000,"m8_hold");
        // 16-bit words, then one with a 3-cycle gap
        addv(0,1,2'b01,1,8'h6b, 8'hdf,16'h0,32'h0,4'b0000,"m16_b0");
        addv(0,1,2'b01,1,8'h57, 8'hdf,16'h6b57,32'h0,4'b0100,"m16_w0");
        addv(0,1,2'b01,1,8'h93, 8'hdf,16'h6b57,32'h0,4'b0000,"m16_b2");
        addv(0,1,2'b01,1,8'h17, 8'hdf,16'h9317,32'h0,4'b0100,"m16_w1");
        addv(0,1,2'b01,1,8'h6b, 8'hdf,16'h9317,32'h0,4'b0000,"gap_b0");
        for (int i = 0; i < 3; i++) addv(0,1,2'b01,0,8'hee, 8'hdf,16'h9317,32'h0,4'b0000,"gap_idle");
        addv(0,1,2'b01,1,8'h57, 8'hdf,16'h6b57,32'h0,4'b0100,"gap_w");
        // 32-bit words
        addv(0,1,2'b10,1,8'h52, 8'hdf,16'h6b57,32'h0,4'b0000,"m32_b0");
        addv(0,1,2'b10,1,8'hd5, 8'hdf,16'h6b57,32'h0,4'b0000,"m32_b1");
        addv(0,1,2'b10,1,8'ha8, 8'hdf,16'h6b57,32'h0,4'b0000,"m32_b2");
        addv(0,1,2'b10,1,8'hf9, 8'hdf,16'h6b57,32'h52d5a8f9,4'b0010,"m32_w0");
        addv(0,1,2'b10,1,8'h01, 8'hdf,16'h6b57,32'h52d5a8f9,4'b0000,"m32_b4");
        addv(0,1,2'b10,1,8'hc5, 8'hdf,16'h6b57,32'h52d5a8f9,4'b0000,"m32_b5");
        addv(0,1,2'b10,1,8'h91, 8'hdf,16'h6b57,32'h52d5a8f9,4'b0000,"m32_b6");
        addv(0,1,2'b10,1,8'h11, 8'hdf,16'h6b57,32'h01c59111,4'b0010,"m32_w1");
        addv(0,1,2'b10,0,8'h00, 8'hdf,16'h6b57,32'h01c59111,4'b0000,"m32_after");
        // Mode switch mid-word: error, and the switching byte starts the new word
        addv(0,1,2'b10,1,8'h10, 8'hdf,16'h6b57,32'h01c59111,4'b0000,"sw_b0");
        addv(0,1,2'b10,1,8'hf6, 8'hdf,16'h6b57,32'h01c59111,4'b0000,"sw_b1");
        addv(0,1,2'b01,1,8'h9f, 8'hdf,16'h6b57,32'h01c59111,4'b0001,"sw_err");
        addv(0,1,2'b01,1,8'h8a, 8'hdf,16'h9f8a,32'h01c59111,4'b0100,"sw_w");
        // Enable low mid-word, including an idle code and a mode change that must be ignored
        addv(0,1,2'b01,1,8'he3, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_b0");
        addv(0,0,2'b01,1,8'haa, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_off");
        addv(0,0,2'b11,1,8'hbb, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_off_idle");
        addv(0,0,2'b00,1,8'hcc, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_off_m8");
        addv(0,0,2'b01,0,8'hdd, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_off");
        addv(0,0,2'b01,1,8'hee, 8'hdf,16'h9f8a,32'h01c59111,4'b0000,"enb_off");
        addv(0,1,2'b01,1,8'hc6, 8'hdf,16'he3c6,32'h01c59111,4'b0100,"enb_w");
        // Reset mid-word discards silently
        addv(0,1,2'b10,1,8'h77, 8'hdf,16'he3c6,32'h01c59111,4'b0000,"rst_b0");
        addv(1,1,2'b10,1,8'h78, 8'h00,16'h0,32'h0,4'b0000,"rst_mid");
        addv(0,1,2'b10,0,8'h00, 8'h00,16'h0,32'h0,4'b0000,"rst_after");
        // Idle-state mode switches are silent; idle code mid-word raises an error
        addv(0,1,2'b00,1,8'h12, 8'h12,16'h0,32'h0,4'b1000,"idle_m8");
        addv(0,1,2'b01,1,8'h34, 8'h12,16'h0,32'h0,4'b0000,"idle_sw16");
        addv(0,1,2'b01,1,8'h56, 8'h12,16'h3456,32'h0,4'b0100,"idle_w16");
        addv(0,1,2'b10,1,8'h01, 8'h12,16'h3456,32'h0,4'b0000,"idle_sw32");
        addv(0,1,2'b11,1,8'h99, 8'h12,16'h3456,32'h0,4'b0001,"stop_err");
        addv(0,1,2'b11,1,8'h98, 8'h12,16'h3456,32'h0,4'b0000,"stop_ignore");
        addv(0,1,2'b00,1,8'hab, 8'hab,16'h3456,32'h0,4'b1000,"stop_m8");

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].enb, vecs[i].ds, vecs[i].vi, vecs[i].din);
            check(vecs[i].name, vecs[i].e8, vecs[i].e16, vecs[i].e32, vecs[i].stb);
        end

        // Randomized traffic against the model, starting from a clean reset
        modelStep(1, 1, 2'b00, 0, 8'h00);
        drive(1, 1, 2'b00, 0, 8'h00);
        check("rand_reset", m8, m16, m32, mStb);
        ds = 2'b01;
        for (int c = 0; c < 3000; c++) begin
            r   = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) ds = 2'($urandom_range(0, 3));
            vi  = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            modelStep(r, e, ds, vi, din);
            drive(r, e, ds, vi, din);
            check("rand", m8, m16, m32, mStb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
